// File: rtl/core_sequencer_if.sv
// ---------------------------------------------------------------------------
// core_sequencer_if
//   Instruction- and data-memory handshake bundle between the core sequencer
//   (master) and the memory subsystem (slave).
//
//   imem_req_valid  master->slave  fetch request
//   imem_req_ready  slave->master  instruction memory accepts request
//   imem_req_addr   master->slave  fetch address (XLEN)
//   imem_resp_valid slave->master  fetch data valid
//   imem_resp_data  slave->master  fetched instruction (32)
//   dmem_req_valid  master->slave  data access request
//   dmem_req_ready  slave->master  data memory accepts request
//   dmem_resp_valid slave->master  load data ready / store acknowledged
// ---------------------------------------------------------------------------
interface core_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic            dmem_resp_valid;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output dmem_req_valid,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  dmem_req_ready,
        input  dmem_resp_valid
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  dmem_req_valid,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output dmem_req_ready,
        output dmem_resp_valid
    );
endinterface

// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle control sequencer for the RV32 core. Fetches one instruction
//   at a time over the imem handshake, latches it for decode, optionally runs
//   one data access over the dmem handshake, and then commits the instruction
//   in a single COMMIT cycle so PC and register file are written exactly once.
//   Stops on ebreak (halted) or on a memory wait that exceeds TIMEOUT cycles
//   (bus_err); both are sticky until reset.
//
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   pc        in   current PC register value
//   mem       ---  memory handshake bundle (master side)
//   inst      out  latched instruction for decode
//   is_load   in   decoded load
//   is_store  in   decoded store
//   dec_wen   in   control-unit register write request
//   halt_req  in   decoded ebreak
//   pc_wen    out  PC register write enable (COMMIT only)
//   reg_wen   out  register file write enable (COMMIT only)
//   retire    out  one-cycle pulse per committed instruction
//   halted    out  sticky, ebreak committed
//   bus_err   out  sticky, memory wait timed out
// ---------------------------------------------------------------------------
module core_sequencer #(
    parameter int unsigned XLEN    = 32,
    parameter logic [7:0]  TIMEOUT = 8'd255,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [XLEN-1:0]        pc,
    core_sequencer_if.master       mem,
    output logic [31:0]            inst,
    input  logic                   is_load,
    input  logic                   is_store,
    input  logic                   dec_wen,
    input  logic                   halt_req,
    output logic                   pc_wen,
    output logic                   reg_wen,
    output logic                   retire,
    output logic                   halted,
    output logic                   bus_err
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_IWAIT  = 4'd2;
    localparam logic [3:0] S_EXEC   = 4'd3;
    localparam logic [3:0] S_MEM    = 4'd4;
    localparam logic [3:0] S_MWAIT  = 4'd5;
    localparam logic [3:0] S_COMMIT = 4'd6;
    localparam logic [3:0] S_HALT   = 4'd7;
    localparam logic [3:0] S_ERR    = 4'd8;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_inst;
    logic        r_halt;     // instruction in flight is ebreak
    logic        r_wen;      // register write allowed at commit
    logic        w_waiting;  // state is a memory wait state
    logic        w_timeout;

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_IWAIT) ||
                       (r_state == S_MEM)   || (r_state == S_MWAIT);
    assign w_timeout = (r_cnt == TIMEOUT);

    // Next-state logic. A completing handshake is tested before the timeout,
    // so a handshake in the very cycle the count reaches TIMEOUT wins.
    // NOTE: w_next gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (mem.imem_req_ready)       w_next = S_IWAIT;
                else if (w_timeout)           w_next = S_ERR;
            end
            S_IWAIT: begin
                if (mem.imem_resp_valid)      w_next = S_EXEC;
                else if (w_timeout)           w_next = S_ERR;
            end
            S_EXEC: begin
                if (halt_req)                 w_next = S_COMMIT;
                else if (is_load || is_store) w_next = S_MEM;
                else                          w_next = S_COMMIT;
            end
            S_MEM: begin
                if (mem.dmem_req_ready)       w_next = S_MWAIT;
                else if (w_timeout)           w_next = S_ERR;
            end
            S_MWAIT: begin
                if (mem.dmem_resp_valid)      w_next = S_COMMIT;
                else if (w_timeout)           w_next = S_ERR;
            end
            S_COMMIT: w_next = r_halt ? S_HALT : S_FETCH;
            S_HALT:   w_next = S_HALT;
            S_ERR:    w_next = S_ERR;
            default:  w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_inst  <= NOP;
            r_halt  <= 1'b0;
            r_wen   <= 1'b0;
        end else begin
            r_state <= w_next;

            // Every state change restarts the count, which covers entry into
            // each wait state; it can never pass TIMEOUT because reaching it
            // forces a state change.
            if (w_next != r_state) begin
                r_cnt <= 8'd0;
            end else if (w_waiting) begin
                r_cnt <= r_cnt + 8'd1;
            end

            // Responses are only looked at in IWAIT; stale ones are dropped.
            if ((r_state == S_IWAIT) && mem.imem_resp_valid) begin
                r_inst <= mem.imem_resp_data;
            end

            // Decode outputs are captured once in EXEC so COMMIT sees a
            // consistent flavour. A pure store never writes a register; a
            // combined load/store follows the load rule.
            if (r_state == S_EXEC) begin
                r_halt <= halt_req;
                r_wen  <= dec_wen && !halt_req && !(is_store && !is_load);
            end
        end
    end

    // The PC register commits on the same edge that enters FETCH, so the
    // address is taken from pc while in FETCH rather than registered on entry.
    // pc_wen is 0 throughout FETCH, so the address stays stable until ready.
    assign mem.imem_req_valid = (r_state == S_FETCH);
    assign mem.imem_req_addr  = (r_state == S_FETCH) ? pc : '0;
    assign mem.dmem_req_valid = (r_state == S_MEM);

    assign inst    = r_inst;
    assign retire  = (r_state == S_COMMIT);
    assign pc_wen  = (r_state == S_COMMIT) && !r_halt;
    assign reg_wen = (r_state == S_COMMIT) && r_wen;
    assign halted  = (r_state == S_HALT);
    assign bus_err = (r_state == S_ERR);

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] inst;
        logic        reg_wen;
        logic        pc_wen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc  = 32'd0;
    logic [31:0] inst;
    logic        is_load  = 1'b0;
    logic        is_store = 1'b0;
    logic        dec_wen  = 1'b0;
    logic        halt_req = 1'b0;
    logic        pc_wen, reg_wen, retire, halted, bus_err;

    always #5 clk = ~clk;

    core_sequencer_if #(.XLEN(32)) bus ();

    core_sequencer #(
        .XLEN    (32),
        .TIMEOUT (8'd255),
        .NOP     (NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .mem      (bus.master),
        .inst     (inst),
        .is_load  (is_load),
        .is_store (is_store),
        .dec_wen  (dec_wen),
        .halt_req (halt_req),
        .pc_wen   (pc_wen),
        .reg_wen  (reg_wen),
        .retire   (retire),
        .halted   (halted),
        .bus_err  (bus_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // memory agent configuration and state
    int          imem_rdy_dly, dmem_rdy_dly, dmem_rsp_dly;
    bit          imem_stall;
    int          iwait, dwait, dresp_left, late_dresp;
    bit          iresp_pend;
    logic [31:0] pend_word;
    bit          use_fixed;
    logic [31:0] fixed_word;

    // observation
    exp_t        sb_q[$];
    int          retire_cycs[$];
    int          n_retire, n_pcw, n_regw, n_ivalid, n_dvalid;
    int          first_fetch_cyc;
    logic [31:0] first_fetch_addr, first_fetch_inst;

    function automatic logic [31:0] word_for(input logic [31:0] a);
        return use_fixed ? fixed_word : {a[11:0], 20'h00093};
    endfunction

    function automatic int retire_at(input int i);
        return (retire_cycs.size() > i) ? retire_cycs[i] : -100000;
    endfunction

    task automatic clear_agent();
        imem_rdy_dly = 0; dmem_rdy_dly = 0; dmem_rsp_dly = 1; imem_stall = 1'b0;
        iwait = 0; dwait = 0; dresp_left = 0; late_dresp = 0; iresp_pend = 1'b0;
        use_fixed = 1'b0; fixed_word = NOP; pend_word = NOP;
        sb_q.delete(); retire_cycs.delete();
        n_retire = 0; n_pcw = 0; n_regw = 0; n_ivalid = 0; n_dvalid = 0;
        first_fetch_cyc = -1; first_fetch_addr = '0; first_fetch_inst = '0;
        is_load = 1'b0; is_store = 1'b0; dec_wen = 1'b0; halt_req = 1'b0;
        bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
        bus.dmem_req_ready = 1'b0; bus.dmem_resp_valid = 1'b0;
    endtask

    // One clock cycle: observe outputs at the falling edge, score retirements,
    // update the PC model, then drive memory responses for the next edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus.imem_req_valid) n_ivalid++;
        if (bus.dmem_req_valid) n_dvalid++;
        if (pc_wen)  n_pcw++;
        if (reg_wen) n_regw++;
        if (bus.imem_req_valid && first_fetch_cyc < 0) begin
            first_fetch_cyc  = cyc;
            first_fetch_addr = bus.imem_req_addr;
            first_fetch_inst = inst;
        end

        checks++;
        if ((pc_wen || reg_wen) && !retire) begin
            errors++;
            $display("FAIL wen_outside_commit cyc=%0d: pc_wen=%b reg_wen=%b retire=%b (want no enable without retire)",
                     cyc, pc_wen, reg_wen, retire);
        end

        if (retire) begin
            n_retire++;
            retire_cycs.push_back(cyc);
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected cyc=%0d: retire=1, no instruction outstanding", cyc);
            end else begin
                e = sb_q.pop_front();
                if (inst !== e.inst || reg_wen !== e.reg_wen || pc_wen !== e.pc_wen) begin
                    errors++;
                    $display("FAIL commit cyc=%0d: inst=%h reg_wen=%b pc_wen=%b, want inst=%h reg_wen=%b pc_wen=%b",
                             cyc, inst, reg_wen, pc_wen, e.inst, e.reg_wen, e.pc_wen);
                end
            end
        end

        if (pc_wen) pc = pc + 32'd4;

        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.dmem_req_ready  = 1'b0;
        bus.dmem_resp_valid = 1'b0;

        if (late_dresp > 0) begin
            bus.dmem_resp_valid = 1'b1;
            late_dresp--;
        end

        if (iresp_pend) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = pend_word;
            e.inst    = pend_word;
            e.pc_wen  = !halt_req;
            e.reg_wen = dec_wen && !halt_req && !(is_store && !is_load);
            sb_q.push_back(e);
            iresp_pend = 1'b0;
        end

        if (bus.imem_req_valid) begin
            if (!imem_stall && iwait == imem_rdy_dly) begin
                bus.imem_req_ready = 1'b1;
                iresp_pend = 1'b1;
                pend_word  = word_for(pc);
                iwait      = 0;
                checks++;
                if (bus.imem_req_addr !== pc) begin
                    errors++;
                    $display("FAIL fetch_addr cyc=%0d: addr=%h, want %h", cyc, bus.imem_req_addr, pc);
                end
            end else begin
                iwait++;
            end
        end

        if (dresp_left > 0) begin
            dresp_left--;
            if (dresp_left == 0) bus.dmem_resp_valid = 1'b1;
        end
        if (bus.dmem_req_valid) begin
            if (dwait == dmem_rdy_dly) begin
                bus.dmem_req_ready = 1'b1;
                dwait      = 0;
                dresp_left = dmem_rsp_dly;
            end else begin
                dwait++;
            end
        end
    endtask

    task automatic apply_reset(input logic [31:0] new_pc);
        @(negedge clk);
        #2 rst = 1'b0;
        clear_agent();
        pc = new_pc;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_until_retire(input int n, input int budget);
        for (int i = 0; i < budget && n_retire < n; i++) tick();
        checks++;
        if (n_retire < n) begin
            errors++;
            $display("FAIL retire_timeout: retired %0d, want %0d within %0d cycles", n_retire, n, budget);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_quiet_outputs(input string name);
        checks++;
        if ({bus.imem_req_valid, bus.dmem_req_valid, pc_wen, reg_wen, retire, halted, bus_err} !== 7'b0 ||
            bus.imem_req_addr !== 32'd0) begin
            errors++;
            $display("FAIL %s outputs: ireq=%b addr=%h dreq=%b pc_wen=%b reg_wen=%b retire=%b halted=%b bus_err=%b, want all 0",
                     name, bus.imem_req_valid, bus.imem_req_addr, bus.dmem_req_valid, pc_wen, reg_wen,
                     retire, halted, bus_err);
        end
        checks++;
        if (inst !== NOP) begin
            errors++;
            $display("FAIL %s inst: got %h, want %h", name, inst, NOP);
        end
    endtask

    task automatic test_reset();
        clear_agent();
        pc = 32'h8000_0000;
        @(negedge clk);
        @(negedge clk);
        check_quiet_outputs("reset");
    endtask

    task automatic test_addi_stream();
        apply_reset(32'h8000_0000);
        dec_wen = 1'b1;
        run_until_retire(4, 40);
        checks++;
        if (first_fetch_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL first_fetch_addr: got %h, want 80000000", first_fetch_addr);
        end
        checks++;
        if (first_fetch_inst !== NOP) begin
            errors++;
            $display("FAIL inst_before_resp: got %h, want %h", first_fetch_inst, NOP);
        end
        check_int("addi_first_latency", retire_at(0) - first_fetch_cyc, 3);
        for (int i = 1; i < 4; i++) check_int("addi_retire_spacing", retire_at(i) - retire_at(i - 1), 4);
        check_int("addi_pc_wen_count", n_pcw, 4);
        check_int("addi_reg_wen_count", n_regw, 4);
        checks++;
        if (pc !== 32'h8000_0010) begin
            errors++;
            $display("FAIL addi_pc: got %h, want 80000010", pc);
        end
    endtask

    task automatic test_load_wait();
        apply_reset(32'h0000_0100);
        is_load = 1'b1; dec_wen = 1'b1;
        dmem_rdy_dly = 3; dmem_rsp_dly = 2;
        run_until_retire(1, 40);
        check_int("load_dreq_cycles", n_dvalid, 4);
        check_int("load_latency", retire_at(0) - first_fetch_cyc, 9);
        check_int("load_reg_wen_count", n_regw, 1);
        check_int("load_pc_wen_count", n_pcw, 1);
    endtask

    task automatic test_store();
        apply_reset(32'h0000_0200);
        is_store = 1'b1; dec_wen = 1'b1;
        run_until_retire(1, 40);
        check_int("store_reg_wen_count", n_regw, 0);
        check_int("store_pc_wen_count", n_pcw, 1);
        check_int("store_latency", retire_at(0) - first_fetch_cyc, 5);
    endtask

    task automatic test_back_to_back();
        apply_reset(32'h0000_0300);
        is_load = 1'b1; is_store = 1'b1; dec_wen = 1'b1;
        run_until_retire(3, 60);
        check_int("ldst_reg_wen_count", n_regw, 3);
        for (int i = 1; i < 3; i++) check_int("ldst_retire_spacing", retire_at(i) - retire_at(i - 1), 6);
    endtask

    task automatic test_halt();
        int ivalid_at_halt;
        apply_reset(32'h0000_0400);
        use_fixed = 1'b1; fixed_word = 32'h0010_0073; halt_req = 1'b1;
        run_until_retire(1, 40);
        ivalid_at_halt = n_ivalid;
        for (int i = 0; i < 50; i++) tick();
        check_int("halt_fetches_after", n_ivalid - ivalid_at_halt, 0);
        check_int("halt_retire_count", n_retire, 1);
        check_int("halt_pc_wen_count", n_pcw, 0);
        checks++;
        if (halted !== 1'b1 || pc !== 32'h0000_0400) begin
            errors++;
            $display("FAIL halt_state: halted=%b pc=%h, want halted=1 pc=00000400", halted, pc);
        end
    endtask

    task automatic test_timeout();
        apply_reset(32'h0000_0500);
        imem_stall = 1'b1;
        for (int i = 0; i < 5 && first_fetch_cyc < 0; i++) tick();
        for (int i = 0; i < 300 && cyc < first_fetch_cyc + 255; i++) tick();
        checks++;
        if (bus_err !== 1'b0 || bus.imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cycle255: bus_err=%b ireq=%b, want bus_err=0 ireq=1", bus_err, bus.imem_req_valid);
        end
        tick();
        checks++;
        if (bus_err !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cycle256: bus_err=%b ireq=%b, want bus_err=1 ireq=0", bus_err, bus.imem_req_valid);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus_err !== 1'b1 || n_ivalid != 256) begin
            errors++;
            $display("FAIL timeout_sticky: bus_err=%b fetch_cycles=%0d, want 1 and 256", bus_err, n_ivalid);
        end

        apply_reset(32'h0000_0600);
        imem_rdy_dly = 255;
        dec_wen = 1'b1;
        run_until_retire(1, 300);
        check_int("ready_at_255_latency", retire_at(0) - first_fetch_cyc, 258);
        check_int("ready_at_255_bus_err", int'(bus_err), 0);
    endtask

    task automatic test_reset_mid();
        bit in_mwait;
        apply_reset(32'h0000_0700);
        is_load = 1'b1; dec_wen = 1'b1;
        dmem_rsp_dly = 20;
        in_mwait = 1'b0;
        for (int i = 0; i < 40 && !in_mwait; i++) begin
            tick();
            in_mwait = (dresp_left > 0) && !bus.dmem_req_valid && !bus.dmem_req_ready;
        end
        checks++;
        if (!in_mwait) begin
            errors++;
            $display("FAIL reach_mwait: not reached within budget");
        end
        #2 rst = 1'b0;
        #1 check_quiet_outputs("async_reset");
        clear_agent();
        pc = 32'h0000_1000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.dmem_resp_valid = 1'b1;
        late_dresp = 3;
        dec_wen = 1'b1;
        run_until_retire(1, 20);
        checks++;
        if (first_fetch_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL refetch_addr: got %h, want 00001000", first_fetch_addr);
        end
        check_int("refetch_latency", retire_at(0) - first_fetch_cyc, 3);
        check_int("refetch_dreq_cycles", n_dvalid, 0);
        check_int("refetch_reg_wen_count", n_regw, 1);
    endtask

    initial begin
        test_reset();
        test_addi_stream();
        test_load_wait();
        test_store();
        test_back_to_back();
        test_halt();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
